cb_lane_dispatch: RTL and testbench
===================================

// Module: cb_lane_dispatch
// PURPOSE
//  Block-level scheduler between the code-block segmentation output and NUM_LANES parallel
//  turbo-encoder lanes. Grants each whole code block (start byte .. last byte) to one lane,
//  round-robin among lanes advertising room for a full block; stalls segmentation otherwise.
//  Registered 1-cycle byte path; lane select is held constant for the whole block.
// PARAMETERS
//  NUM_LANES      4    encoder lanes, 2..8
//  K_PLUS_BYTES   768  bytes per block when in_size=1 (K+ = 6144 bits)
//  K_MINUS_BYTES  760  bytes per block when in_size=0 (K- = 6080 bits)
// PORTS
//  clk         in   1          single clock, all logic on rising edge
//  reset       in   1          synchronous, active-low
//  in_valid    in   1          byte on in_data valid
//  in_start    in   1          in_data is first byte of a code block
//  in_size     in   1          block size select, valid with in_start
//  in_data     in   8          code-block byte
//  in_ready    out  1          byte accepted when in_valid & in_ready
//  lane_free   in   NUM_LANES  lane i can absorb one full block now
//  out_lane    out  NUM_LANES  one-hot destination; byte valid when any bit set
//  out_data    out  8          forwarded byte
//  out_start   out  1          first byte of block
//  out_last    out  1          final byte of block
//  out_size    out  1          latched in_size, constant across block
//  out_abort   out  1          1-cycle pulse to current lane: block truncated, discard it
//  err_pulse   out  1          1-cycle pulse on any protocol error
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE, rr_ptr=NUM_LANES-1, all outputs 0, counter 0.
//  FSM IDLE:   in_ready=0. If in_valid & in_start & |lane_free: grant = first lane with
//              lane_free=1 searching rr_ptr+1 upward with wrap; latch lane, in_size;
//              cnt = size?K_PLUS_BYTES:K_MINUS_BYTES; rr_ptr<=grant; -> STREAM.
//              If in_valid & !in_start: consume byte (in_ready=1 that cycle), err_pulse, stay.
//              No lane free: hold (in_ready=0), no error.
//  STREAM:     in_ready=1. Each accepted beat: next cycle out_lane=one-hot grant, out_data,
//              out_start=(first beat), out_last=(cnt==1), cnt<=cnt-1. Beat with cnt==1 -> IDLE.
//              in_valid gaps allowed: out_lane=0 in gap cycles. lane_free ignored here.
//              in_start on a non-first beat: out_abort + err_pulse to old lane, byte NOT
//              forwarded, -> IDLE without consuming (in_ready=0 that cycle) so it re-arbitrates.
//  in_start on first STREAM beat is required; absent -> same abort path.
//  Latency in->out 1 cycle; grant decision 1 cycle; min inter-block gap 1 idle cycle.
//  Counter width clog2(K_PLUS_BYTES+1); sizes fixed at elaboration.
//  Reset mid-block: all outputs 0 next cycle, no abort/last issued; lanes reset alongside.
//  Simultaneous: last beat + in_start on next cycle -> normal IDLE re-arbitration.
// CONFIGURATION
//  CB_LANE_DISPATCH_STATS_EN defined: extra outputs blk_cnt[15:0] (blocks completed with
//   out_last, wraps 0xFFFF->0) and err_cnt[7:0] (err_pulse count, saturates at 0xFF);
//   both cleared by reset, update 1 cycle after the event.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  lane_free=4'b1111, 4 blocks size=1 back-to-back -> lanes 0,1,2,3 in order; 768 beats each,
//   out_start on beat 0, out_last on beat 767, out_size=1.
//  lane_free=4'b0100, block size=0 -> lane 2 only, 760 beats; next block with lane_free=0 ->
//   in_ready stays 0 until lane_free!=0.
//  Random in_valid gaps (50%) within block -> byte order/count intact, out_lane=0 in gaps.
//  in_start at beat 100 of lane-1 block -> out_abort 1 cycle, err_pulse, new block to lane 2,
//   its start byte forwarded intact.
//  in_valid without in_start in IDLE -> byte dropped, err_pulse, nothing on out_lane.
//  reset low at beat 300 -> next cycle all outputs 0, rr_ptr=3; next block -> lane 0.

Source files
------------

// File: rtl/cb_lane_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : cb_lane_dispatch
// Purpose  : Grants whole code blocks from segmentation to one of NUM_LANES
//            turbo-encoder lanes, round-robin among lanes with room for a
//            full block. Registered one-cycle byte path.
// Options  : CB_LANE_DISPATCH_STATS_EN adds blk_cnt / err_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cb_lane_dispatch #(
    parameter int NUM_LANES     = 4,
    parameter int K_PLUS_BYTES  = 768,
    parameter int K_MINUS_BYTES = 760
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic                 in_size,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic [NUM_LANES-1:0] lane_free,
    output logic [NUM_LANES-1:0] out_lane,
    output logic [7:0]           out_data,
    output logic                 out_start,
    output logic                 out_last,
    output logic                 out_size,
    output logic                 out_abort,
`ifdef CB_LANE_DISPATCH_STATS_EN
    output logic [15:0]          blk_cnt,
    output logic [7:0]           err_cnt,
`endif
    output logic                 err_pulse
);

    localparam int c_PTR_W = $clog2(NUM_LANES);
    localparam int c_CNT_W = $clog2(K_PLUS_BYTES + 1);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_STREAM = 1'b1;

    localparam logic [NUM_LANES-1:0] c_LANE_ONE = NUM_LANES'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_KP   = c_CNT_W'(K_PLUS_BYTES);
    localparam logic [c_CNT_W-1:0]   c_CNT_KM   = c_CNT_W'(K_MINUS_BYTES);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_grant;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_first;
    logic                 r_size;

    logic [NUM_LANES-1:0] r_out_lane;
    logic [7:0]           r_out_data;
    logic                 r_out_start;
    logic                 r_out_last;
    logic                 r_out_abort;
    logic                 r_err_pulse;

    logic [c_PTR_W-1:0]   w_grant;
    logic                 w_any_free;
    logic                 w_grant_go;
    logic                 w_beat;
    logic                 w_abort;
    logic                 w_idle_err;

    // Walk downward so the last hit is the nearest lane above rr_ptr.
    always_comb begin : p_grant_search
        int               w_idx;
        logic [c_PTR_W-1:0] w_sel;
        w_grant    = '0;
        w_any_free = 1'b0;
        w_idx      = 0;
        w_sel      = '0;
        for (int i = NUM_LANES; i >= 1; i--) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_LANES;
            w_sel = c_PTR_W'(w_idx);
            if (lane_free[w_sel]) begin
                w_grant    = w_sel;
                w_any_free = 1'b1;
            end
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_grant_go  = 1'b0;
        w_beat      = 1'b0;
        w_abort     = 1'b0;
        w_idle_err  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    if (!in_start) begin
                        in_ready   = 1'b1;
                        w_idle_err = 1'b1;
                    end else if (w_any_free) begin
                        w_grant_go  = 1'b1;
                        w_state_nxt = c_ST_STREAM;
                    end
                end
            end
            c_ST_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Start flag must appear exactly on the first beat; otherwise
                    // drop the block and leave the byte for re-arbitration.
                    if (in_start != r_first) begin
                        in_ready    = 1'b0;
                        w_abort     = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_beat = 1'b1;
                        if (r_cnt == c_CNT_ONE) begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= c_PTR_W'(NUM_LANES - 1);
            r_grant     <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_size      <= 1'b0;
            r_out_lane  <= '0;
            r_out_data  <= '0;
            r_out_start <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_abort <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_lane  <= '0;
            r_out_start <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_abort <= w_abort;
            r_err_pulse <= w_abort | w_idle_err;
            if (w_grant_go) begin
                r_grant  <= w_grant;
                r_rr_ptr <= w_grant;
                r_size   <= in_size;
                r_cnt    <= in_size ? c_CNT_KP : c_CNT_KM;
                r_first  <= 1'b1;
            end
            if (w_beat) begin
                r_out_lane  <= c_LANE_ONE << r_grant;
                r_out_data  <= in_data;
                r_out_start <= r_first;
                r_out_last  <= (r_cnt == c_CNT_ONE);
                r_cnt       <= r_cnt - c_CNT_ONE;
                r_first     <= 1'b0;
            end
        end
    end

    assign out_lane  = r_out_lane;
    assign out_data  = r_out_data;
    assign out_start = r_out_start;
    assign out_last  = r_out_last;
    assign out_size  = r_size;
    assign out_abort = r_out_abort;
    assign err_pulse = r_err_pulse;

`ifdef CB_LANE_DISPATCH_STATS_EN
    logic [15:0] r_blk_cnt;
    logic [7:0]  r_err_cnt;

    // Counters follow the registered pulses, so they lag the event by a cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blk_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_out_last) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
            if (r_err_pulse && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign blk_cnt = r_blk_cnt;
    assign err_cnt = r_err_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_lane_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_lane_dispatch
// Purpose  : Randomized scoreboard bench for cb_lane_dispatch with a
//            transaction-level round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cb_lane_dispatch;

    localparam int NL = 4;
    localparam int KP = 768;
    localparam int KM = 760;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_start;
    logic          in_size;
    logic [7:0]    in_data;
    logic          in_ready;
    logic [NL-1:0] lane_free;
    logic [NL-1:0] out_lane;
    logic [7:0]    out_data;
    logic          out_start;
    logic          out_last;
    logic          out_size;
    logic          out_abort;
    logic          err_pulse;

    always #5 clk = ~clk;

    cb_lane_dispatch #(
        .NUM_LANES    (NL),
        .K_PLUS_BYTES (KP),
        .K_MINUS_BYTES(KM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_start (in_start),
        .in_size  (in_size),
        .in_data  (in_data),
        .in_ready (in_ready),
        .lane_free(lane_free),
        .out_lane (out_lane),
        .out_data (out_data),
        .out_start(out_start),
        .out_last (out_last),
        .out_size (out_size),
        .out_abort(out_abort),
        .err_pulse(err_pulse)
    );

    typedef struct {
        logic [NL-1:0] lane;
        logic [7:0]    data;
        logic          start;
        logic          last;
        logic          size;
        logic          abort;
        logic          err;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         rr;
    bit         mon_en   = 1'b0;
    bit         use_carry = 1'b0;
    logic [7:0] carry_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference arbiter: nearest free lane strictly after the last grant.
    function automatic int pick(input logic [NL-1:0] lf);
        for (int i = 1; i <= NL; i++) begin
            int idx;
            idx = (rr + i) % NL;
            if (lf[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic push_beat(input int lane, input logic [7:0] d, input bit s, input bit l, input bit sz);
        ev_t e;
        e.lane  = NL'(1) << lane;
        e.data  = d;
        e.start = s;
        e.last  = l;
        e.size  = sz;
        e.abort = 1'b0;
        e.err   = 1'b1 & 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input bit ab);
        ev_t e;
        e.lane  = '0;
        e.data  = '0;
        e.start = 1'b0;
        e.last  = 1'b0;
        e.size  = 1'b0;
        e.abort = ab;
        e.err   = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit v, input bit s, input bit sz, input logic [7:0] d,
                        input logic [NL-1:0] lf, input bit exp_rdy);
        in_valid  = v;
        in_start  = s;
        in_size   = sz;
        in_data   = d;
        lane_free = lf;
        #1;
        chk("in_ready", in_ready, exp_rdy);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lane"},  out_lane,  0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_start"}, out_start, 0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_size"},  out_size,  0);
        chk({tag, "_abort"}, out_abort, 0);
        chk({tag, "_err"},   err_pulse, 0);
    endtask

    // One block: grant cycle, then n beats with optional gaps, abort or reset.
    task automatic send_block(input bit sz, input logic [NL-1:0] lf, input int gap_pct,
                              input int abort_at, input int reset_at);
        int         lane;
        int         n;
        logic [7:0] d;
        n    = sz ? KP : KM;
        lane = pick(lf);
        d    = use_carry ? carry_d : 8'($urandom);
        use_carry = 1'b0;
        step(1'b1, 1'b1, sz, d, lf, 1'b0);
        rr = lane;
        for (int b = 0; b < n; b++) begin
            while ($urandom_range(99) < gap_pct) begin
                step(1'b0, 1'b0, sz, 8'($urandom), NL'($urandom), 1'b1);
            end
            if (b == reset_at) begin
                reset    = 1'b0;
                in_valid = 1'b1;
                in_start = 1'b0;
                in_data  = d;
                @(negedge clk);
                check_all_zero("mid_reset");
                reset = 1'b1;
                rr    = NL - 1;
                return;
            end
            if (b == abort_at) begin
                push_err(1'b1);
                step(1'b1, (b != 0), sz, d, NL'($urandom), 1'b0);
                carry_d   = d;
                use_carry = (b != 0);
                return;
            end
            push_beat(lane, d, (b == 0), (b == n - 1), sz);
            step(1'b1, (b == 0), sz, d, NL'($urandom), 1'b1);
            d = 8'($urandom);
        end
    endtask

    // Monitor: any visible output event must match the head of the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en && ((out_lane != '0) || out_abort || err_pulse)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output lane=%b abort=%b err=%b required=none",
                             out_lane, out_abort, err_pulse);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_lane",  out_lane,  e.lane);
                    chk("out_abort", out_abort, e.abort);
                    chk("err_pulse", err_pulse, e.err);
                    if (e.lane != '0) begin
                        chk("out_data",  out_data,  e.data);
                        chk("out_start", out_start, e.start);
                        chk("out_last",  out_last,  e.last);
                        chk("out_size",  out_size,  e.size);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_start  = 1'b0;
        in_size   = 1'b0;
        in_data   = '0;
        lane_free = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        chk("reset_in_ready", in_ready, 0);
        reset  = 1'b1;
        rr     = NL - 1;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00, '1, 1'b0);

        // Four back-to-back large blocks rotate across all lanes.
        repeat (4) send_block(1'b1, 4'b1111, 0, -1, -1);

        // Single free lane, then no lane free holds the next start.
        send_block(1'b0, 4'b0100, 0, -1, -1);
        repeat (6) step(1'b1, 1'b1, 1'b0, 8'h5A, 4'b0000, 1'b0);
        send_block(1'b0, 4'b1001, 0, -1, -1);

        // Valid gaps inside a block.
        send_block(1'b1, 4'b1111, 50, -1, -1);

        // Early start at beat 100 aborts, the start byte re-arbitrates.
        send_block(1'b1, 4'b1111, 0, 100, -1);
        send_block(1'b0, 4'b1111, 0, -1, -1);

        // Stray bytes while idle are dropped with an error.
        repeat (2) begin
            push_err(1'b0);
            step(1'b1, 1'b0, 1'b0, 8'($urandom), 4'b1111, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'b1111, 1'b0);

        // Missing start on the first streaming beat aborts; byte then dropped in idle.
        send_block(1'b1, 4'b1111, 0, 0, -1);
        push_err(1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hC3, 4'b1111, 1'b1);

        // Reset mid-block restores the pointer so the next grant goes to lane 0.
        send_block(1'b1, 4'b1111, 0, -1, 300);
        send_block(1'b0, 4'b1111, 0, -1, -1);

        repeat (5) send_block(1'($urandom_range(0, 1)), NL'($urandom_range(1, 15)),
                              $urandom_range(0, 40), -1, -1);

        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 4'b1111, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
